axi4_protocol_checker: RTL

AXI4_PROTOCOL_CHECKER -- requirements
Module: axi4_protocol_checker

---
 rtl/axi4_chk_pkg.sv | 26 ++
 rtl/axi4_len_fifo.sv | 66 ++++++
 rtl/axi4_protocol_checker.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/axi4_chk_pkg.sv
// ----------------------------------------------------------------------------
// axi4_chk_pkg
// Shared definitions for the passive AXI4 protocol checker:
//   - ERR_* : bit positions inside the 9-bit err_pulse / err_sticky vectors
//   - resp_legal() : true for the response codes this system accepts
//                    (OKAY = 2'b00, SLVERR = 2'b10)
// ----------------------------------------------------------------------------
package axi4_chk_pkg;

   localparam int ERR_W          = 9;

   localparam int ERR_VALID_DROP = 0;  // VALID withdrawn before READY
   localparam int ERR_ADDR_CHG   = 1;  // AW/AR address or length changed while stalled
   localparam int ERR_WLAST      = 2;  // WLAST disagrees with AWLEN, or W with no AW
   localparam int ERR_RLAST      = 3;  // RLAST disagrees with ARLEN
   localparam int ERR_B_ORPHAN   = 4;  // B with no completed write
   localparam int ERR_R_ORPHAN   = 5;  // R with no outstanding read
   localparam int ERR_RESP       = 6;  // BRESP/RRESP outside {OKAY, SLVERR}
   localparam int ERR_TIMEOUT    = 7;  // pending response stalled too long
   localparam int ERR_Q_OVF      = 8;  // AW/AR accepted with its length queue full

   function automatic logic resp_legal(input logic [1:0] resp);
      return (resp == 2'b00) || (resp == 2'b10);
   endfunction

endpackage

// File: rtl/axi4_len_fifo.sv
// ----------------------------------------------------------------------------
// axi4_len_fifo
// Small FIFO of 8-bit burst lengths (AWLEN or ARLEN) with a show-ahead head.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (clears pointers)
//   push,push_data : enqueue a length (ignored while full)
//   pop            : dequeue the head (ignored while empty)
//   head           : oldest stored length, valid while !empty
//   full, empty    : occupancy flags
// ----------------------------------------------------------------------------
module axi4_len_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] head,
   output logic       full,
   output logic       empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
   localparam logic [PTR_W-1:0] PTR_ONE  = 1;
   localparam logic [PTR_W:0]   CNT_ONE  = 1;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   // NOTE: the storage array has no reset; stale entries are unreachable once
   // the pointers and count are cleared, so only the control state is reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // NOTE: clocked state always uses non-blocking assignments so every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/axi4_protocol_checker.sv
// ----------------------------------------------------------------------------
// axi4_protocol_checker
// Passive monitor of one AXI4 interface. It never drives the bus; it watches
// handshakes and reports protocol violations as registered error bits.
// Ports:
//   ACLK, ARESET        : clock, synchronous active-high reset
//   AW/W/B/AR/R signals : observed bus signals (inputs only)
//   err_clr             : clears err_sticky (errors of the same cycle survive)
//   err_pulse[8:0]      : one-cycle pulse per error seen on the previous edge
//   err_sticky[8:0]     : accumulated errors
//   wr_pending          : completed write bursts awaiting their B
//   rd_pending          : accepted read bursts not yet finished by RLAST
// ----------------------------------------------------------------------------
module axi4_protocol_checker
   import axi4_chk_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT         = 16
) (
   input  logic                                 ACLK,
   input  logic                                 ARESET,
   input  logic                                 AWVALID,
   input  logic                                 AWREADY,
   input  logic [ADDR_W-1:0]                    AWADDR,
   input  logic [7:0]                           AWLEN,
   input  logic                                 WVALID,
   input  logic                                 WREADY,
   input  logic                                 WLAST,
   input  logic                                 BVALID,
   input  logic                                 BREADY,
   input  logic [1:0]                           BRESP,
   input  logic                                 ARVALID,
   input  logic                                 ARREADY,
   input  logic [ADDR_W-1:0]                    ARADDR,
   input  logic [7:0]                           ARLEN,
   input  logic                                 RVALID,
   input  logic                                 RREADY,
   input  logic                                 RLAST,
   input  logic [1:0]                           RRESP,
   input  logic                                 err_clr,
   output logic [ERR_W-1:0]                     err_pulse,
   output logic [ERR_W-1:0]                     err_sticky,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] wr_pending,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] rd_pending
);

   localparam int PEND_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int STALL_W = $clog2(TIMEOUT + 1);
   localparam logic [PEND_W-1:0]  PEND_ONE   = 1;
   localparam logic [PEND_W-1:0]  PEND_MAX   = '1;
   localparam logic [STALL_W-1:0] STALL_ONE  = 1;
   localparam logic [STALL_W-1:0] STALL_MAX  = TIMEOUT[STALL_W-1:0];
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

   // Channel order in the per-channel vectors: {R, AR, B, W, AW}
   logic [4:0]        cur_valid, cur_ready, prev_valid, prev_ready;
   logic [ADDR_W-1:0] prev_awaddr, prev_araddr;
   logic [7:0]        prev_awlen, prev_arlen;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic wq_full, wq_empty, rq_full, rq_empty;
   logic [7:0] wq_head, rq_head, wbeat, rbeat;

   // Queue view including an address accepted on this very edge
   logic       aw_push, ar_push, w_empty_eff, r_empty_eff, w_done, r_done;
   logic [7:0] w_head_eff, r_head_eff;

   logic [PEND_W-1:0]  wr_pending_next, rd_pending_next;
   logic [STALL_W-1:0] wstall, rstall, wstall_next, rstall_next;
   logic               w_stalling, r_stalling;
   logic [ERR_W-1:0]   err_next;

   assign cur_valid = {RVALID, ARVALID, BVALID, WVALID, AWVALID};
   assign cur_ready = {RREADY, ARREADY, BREADY, WREADY, AWREADY};

   assign aw_hs = AWVALID && AWREADY;
   assign w_hs  = WVALID && WREADY;
   assign b_hs  = BVALID && BREADY;
   assign ar_hs = ARVALID && ARREADY;
   assign r_hs  = RVALID && RREADY;

   assign aw_push     = aw_hs && !wq_full;
   assign ar_push     = ar_hs && !rq_full;
   assign w_empty_eff = wq_empty && !aw_push;
   assign r_empty_eff = rq_empty && !ar_push;
   assign w_head_eff  = wq_empty ? AWLEN : wq_head;
   assign r_head_eff  = rq_empty ? ARLEN : rq_head;
   assign w_done      = w_hs && WLAST && !w_empty_eff;
   assign r_done      = r_hs && RLAST && !r_empty_eff;

   // A burst that is pushed and finished on the same edge never enters the
   // queue: the push and the pop cancel.
   axi4_len_fifo #(.DEPTH(MAX_OUTSTANDING)) u_wq (
      .clk       (ACLK),
      .rst       (ARESET),
      .push      (aw_push && !(wq_empty && w_done)),
      .push_data (AWLEN),
      .pop       (w_done && !wq_empty),
      .head      (wq_head),
      .full      (wq_full),
      .empty     (wq_empty)
   );

   axi4_len_fifo #(.DEPTH(MAX_OUTSTANDING)) u_rq (
      .clk       (ACLK),
      .rst       (ARESET),
      .push      (ar_push && !(rq_empty && r_done)),
      .push_data (ARLEN),
      .pop       (r_done && !rq_empty),
      .head      (rq_head),
      .full      (rq_full),
      .empty     (rq_empty)
   );

   assign w_stalling = (wr_pending != '0) && !b_hs;
   assign r_stalling = (rd_pending != '0) && !r_hs;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      err_next        = '0;
      wr_pending_next = wr_pending;
      rd_pending_next = rd_pending;
      wstall_next     = '0;
      rstall_next     = '0;

      err_next[ERR_VALID_DROP] = |(prev_valid & ~prev_ready & ~cur_valid);
      err_next[ERR_ADDR_CHG]   =
         (prev_valid[0] && !prev_ready[0] && AWVALID &&
          ((AWADDR != prev_awaddr) || (AWLEN != prev_awlen))) ||
         (prev_valid[3] && !prev_ready[3] && ARVALID &&
          ((ARADDR != prev_araddr) || (ARLEN != prev_arlen)));
      err_next[ERR_WLAST]    = w_hs && (w_empty_eff || (WLAST != (wbeat == w_head_eff)));
      err_next[ERR_RLAST]    = r_hs && !r_empty_eff && (RLAST != (rbeat == r_head_eff));
      err_next[ERR_B_ORPHAN] = b_hs && (wr_pending == '0);
      err_next[ERR_R_ORPHAN] = r_hs && r_empty_eff;
      err_next[ERR_RESP]     = (BVALID && !resp_legal(BRESP)) || (RVALID && !resp_legal(RRESP));
      err_next[ERR_TIMEOUT]  = (w_stalling && (wstall == STALL_LAST)) ||
                               (r_stalling && (rstall == STALL_LAST));
      err_next[ERR_Q_OVF]    = (aw_hs && wq_full) || (ar_hs && rq_full);

      // Write completions are counted at WLAST and retired by B; a B with
      // nothing pending is the orphan error above and leaves the count at 0.
      case ({w_done, b_hs && (wr_pending != '0)})
         2'b10:   if (wr_pending != PEND_MAX) wr_pending_next = wr_pending + PEND_ONE;
         2'b01:   wr_pending_next = wr_pending - PEND_ONE;
         default: ;
      endcase

      case ({ar_push, r_done && (rd_pending != '0)})
         2'b10:   if (rd_pending != PEND_MAX) rd_pending_next = rd_pending + PEND_ONE;
         2'b01:   rd_pending_next = rd_pending - PEND_ONE;
         default: ;
      endcase

      // Stall counters hold at TIMEOUT so the timeout fires only once per stall
      if (w_stalling) wstall_next = (wstall == STALL_MAX) ? wstall : wstall + STALL_ONE;
      if (r_stalling) rstall_next = (rstall == STALL_MAX) ? rstall : rstall + STALL_ONE;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         prev_valid  <= '0;
         prev_ready  <= '0;
         prev_awaddr <= '0;
         prev_araddr <= '0;
         prev_awlen  <= '0;
         prev_arlen  <= '0;
         wbeat       <= '0;
         rbeat       <= '0;
         wstall      <= '0;
         rstall      <= '0;
         wr_pending  <= '0;
         rd_pending  <= '0;
         err_pulse   <= '0;
         err_sticky  <= '0;
      end else begin
         prev_valid  <= cur_valid;
         prev_ready  <= cur_ready;
         prev_awaddr <= AWADDR;
         prev_araddr <= ARADDR;
         prev_awlen  <= AWLEN;
         prev_arlen  <= ARLEN;
         if (w_hs && !w_empty_eff) wbeat <= WLAST ? 8'd0 : wbeat + 8'd1;
         if (r_hs && !r_empty_eff) rbeat <= RLAST ? 8'd0 : rbeat + 8'd1;
         wstall      <= wstall_next;
         rstall      <= rstall_next;
         wr_pending  <= wr_pending_next;
         rd_pending  <= rd_pending_next;
         err_pulse   <= err_next;
         err_sticky  <= (err_clr ? '0 : err_sticky) | err_next;
      end
   end

endmodule
